bin_to_bcd_4digit: RTL and testbench
====================================

// Module: bin_to_bcd_4digit
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//  Sits directly upstream of the 4-digit seven-segment controller and feeds it.
//  Converts a binary count (0..9999) into four packed BCD nibbles.
//  The controller displays each nibble on one digit.
//  Inputs above 9999 saturate to 9999 and raise an overflow flag.
// PARAMETERS
//  BIN_W    14     binary input width; sets the conversion length (BIN_W shift cycles)
//  DIGITS   4      BCD digits produced; bcd_out width = 4*DIGITS
//  MAX_VAL  9999   largest representable value; inputs above it saturate
// PORTS
//  clk        in   1         system clock; all state changes on posedge
//  rst        in   1         asynchronous, active-low reset (0 = reset)
//  in_valid   in   1         bin_in is valid this cycle
//  in_ready   out  1         converter idle, can accept; = (state==IDLE)
//  bin_in     in   BIN_W     unsigned binary value
//  out_valid  out  1         one-cycle pulse: bcd_out/overflow updated
//  bcd_out    out  4*DIGITS  packed BCD; [3:0]=ones, [15:12]=thousands; held between pulses
//  overflow   out  1         1 if the last accepted bin_in > MAX_VAL; held with bcd_out
// BEHAVIOUR
//  Reset (rst=0, async assert, sync-released by top level):
//   - state=IDLE, in_ready=1, out_valid=0, bcd_out=0, overflow=0, scratch/counter=0.
//  States:
//   - IDLE: accept when in_valid&&in_ready.
//     - Load bin_in into the shift register and clear the BCD scratch.
//     - Latch ovf = (bin_in > MAX_VAL); set bit counter = BIN_W; go to SHIFT.
//   - SHIFT: each cycle, every scratch nibble >= 5 gets +3 (all nibbles in parallel).
//     - Then the whole {scratch, binary} register shifts left by 1; counter decrements.
//     - On the cycle the counter reaches 0 (BIN_W-th shift), register the result:
//       - bcd_out = ovf ? {DIGITS{4'h9}} : shifted scratch; overflow = ovf.
//       - Assert out_valid for that next cycle only; go to IDLE.
//  Latency:
//   - Acceptance edge E0; shifts on E1..E_BIN_W.
//   - out_valid is high in the cycle after E_BIN_W, i.e. BIN_W cycles after acceptance.
//  Throughput:
//   - in_ready is high in the same cycle as out_valid, so back-to-back accept is allowed.
//   - One conversion per BIN_W+1 cycles.
//  Handshake:
//   - No output backpressure; the downstream block must sample on out_valid or use the held bcd_out.
//   - in_valid while in_ready=0 is ignored; the upstream block holds data until accepted.
//   - bin_in is sampled only on the accept edge.
//  Width rules:
//   - Scratch is 4*DIGITS bits; nibble adjust is 4-bit (value <= 9 after adjust+shift).
//   - The counter is $clog2(BIN_W+1) bits wide.
//  Boundaries:
//   - bin_in=0 gives 0000.
//   - bin_in=MAX_VAL gives 9999 with overflow=0.
//   - bin_in = MAX_VAL+1 .. 2^BIN_W-1 gives 9999 with overflow=1.
//   - The full conversion still runs, so latency is uniform.
//  Reset mid-conversion aborts immediately:
//   - No out_valid is produced.
//   - bcd_out and overflow return to 0.
//  An out_valid pulse never coincides with reset asserted.
// STRUCTURE
//  Shared package/include seg_pkg:
//   - Localparams DIGITS=4, BCD_W=4*DIGITS, MAX_VAL=9999.
//   - State encodings ST_IDLE=1'b0, ST_SHIFT=1'b1.
//   - The seven-seg controller uses the same DIGITS/BCD_W.
//  Sub-module bcd_digit_adj:
//   - Combinational: in[3:0] -> (in>=5 ? in+3 : in).
//   - Instantiated DIGITS times via generate.
//  Top level: state flop, counter, {scratch,binary} shift register, output registers.
// TESTING
//  1. Reset check:
//     - Hold rst=0 mid-sim, then release -> in_ready=1, out_valid=0, bcd_out=16'h0000, overflow=0.
//  2. Single conversion:
//     - bin_in=1234, in_valid 1 cycle.
//     - Expect out_valid exactly 14 cycles after accept, bcd_out=16'h1234, overflow=0.
//     - Expect in_ready=0 for cycles 1..13.
//  3. Limits:
//     - 0 -> 16'h0000.
//     - 9999 -> 16'h9999 with overflow=0.
//     - 10000 and 16383 -> 16'h9999 with overflow=1.
//  4. Back-to-back:
//     - Keep in_valid=1 with 42 then 507.
//     - Second accept in the first out_valid cycle; results 16'h0042 then 16'h0507, 15 cycles apart.
//  5. Busy ignore:
//     - Pulse in_valid with 777 during SHIFT (in_ready=0).
//     - Expect no extra out_valid; the in-flight result is unchanged.
//  6. Reset mid-conversion:
//     - Assert rst at shift 7 of 1234.
//     - Expect no out_valid, bcd_out=0.
//     - A new 56 after release -> 16'h0056.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the binary-to-BCD converter and the seven-segment
// display controller it feeds.
//   DIGITS   : number of BCD digits / display digits
//   BCD_W    : packed BCD width (4 bits per digit)
//   MAX_VAL  : largest value the display can show
//   state_e  : converter FSM state encoding
package seg_pkg;

    localparam int unsigned DIGITS  = 4;
    localparam int unsigned BCD_W   = 4 * DIGITS;
    localparam int unsigned MAX_VAL = 9999;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-nibble add-3 correction used by the shift-and-add-3 converter.
//   nib_i : BCD nibble before the shift
//   nib_o : nib_i + 3 when nib_i >= 5, otherwise nib_i unchanged
module bcd_digit_adj (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    always_comb begin
        nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;
    end

endmodule

// File: rtl/bin_to_bcd_4digit.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 step per clock.
// Inputs above MAX_VAL saturate to all nines and raise overflow.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   in_valid  : bin_in valid this cycle
//   in_ready  : converter idle and able to accept
//   bin_in    : unsigned binary input, sampled only on the accept edge
//   out_valid : one-cycle pulse when bcd_out/overflow are updated
//   bcd_out   : packed BCD result, [3:0] = ones; held between pulses
//   overflow  : last accepted input exceeded MAX_VAL; held with bcd_out
module bin_to_bcd_4digit #(
    parameter int unsigned BIN_W   = 14,
    parameter int unsigned DIGITS  = seg_pkg::DIGITS,
    parameter int unsigned MAX_VAL = seg_pkg::MAX_VAL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    import seg_pkg::*;

    localparam int unsigned SCR_W = 4 * DIGITS;
    localparam int unsigned SH_W  = SCR_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    localparam logic [BIN_W-1:0] MAX_VAL_W = BIN_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SH_W-1:0]    sh_q, sh_d;      // {scratch, binary}
    logic               ovf_q, ovf_d;    // overflow of the in-flight conversion
    logic [SCR_W-1:0]   bcd_q, bcd_d;
    logic               overflow_q, overflow_d;
    logic               out_valid_q, out_valid_d;

    logic [SCR_W-1:0]   scr_adj;
    logic [SH_W-1:0]    sh_next;

    // Every scratch nibble is corrected in parallel before the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .nib_i (sh_q[BIN_W + 4*g +: 4]),
            .nib_o (scr_adj[4*g +: 4])
        );
    end

    assign sh_next = {scr_adj, sh_q[BIN_W-1:0]} << 1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        ovf_d       = ovf_q;
        bcd_d       = bcd_q;
        overflow_d  = overflow_q;
        out_valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sh_d    = {{SCR_W{1'b0}}, bin_in};
                    ovf_d   = (bin_in > MAX_VAL_W);
                    cnt_d   = CNT_INIT;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sh_d  = sh_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Final shift: the shifted scratch is the finished result.
                    bcd_d       = ovf_q ? {DIGITS{4'h9}} : sh_next[SH_W-1 -: SCR_W];
                    overflow_d  = ovf_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            ovf_q       <= 1'b0;
            bcd_q       <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            ovf_q       <= ovf_d;
            bcd_q       <= bcd_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign bcd_out   = bcd_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_4digit.sv
module tb_bin_to_bcd_4digit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] bin_in;
    logic        out_valid;
    logic [15:0] bcd_out;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    bin_to_bcd_4digit #(
        .BIN_W   (14),
        .DIGITS  (4),
        .MAX_VAL (9999)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .out_valid (out_valid),
        .bcd_out   (bcd_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: saturate, then split into decimal digits.
    function automatic logic [15:0] ref_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic logic ref_ovf(input int v);
        return (v > 9999);
    endfunction

    // One conversion; optionally pokes 777 at cycle poke_at while busy.
    task automatic run_conv(input int v, input int poke_at, output int lat, output int busy_bad);
        int  n;
        bit  seen;
        @(negedge clk);
        bin_in   = 14'(v);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        bin_in   = 14'($urandom);
        busy_bad = in_ready ? 1 : 0;
        lat  = 0;
        seen = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen = 1;
                lat  = i;
            end else begin
                if (in_ready) busy_bad++;
                if (i == poke_at) begin
                    in_valid = 1'b1;
                    bin_in   = 14'd777;
                end else if (i == poke_at + 1) begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic check_conv(input string tag, input int v);
        int lat, busy_bad;
        run_conv(v, 0, lat, busy_bad);
        check_eq({tag, "_lat"}, 32'(lat), 32'd14);
        check_eq({tag, "_bcd"}, {16'h0, bcd_out}, {16'h0, ref_bcd(v)});
        check_eq({tag, "_ovf"}, {31'h0, overflow}, {31'h0, ref_ovf(v)});
        check_eq({tag, "_busy"}, 32'(busy_bad), 32'd0);
        @(posedge clk);
        #1;
        check_eq({tag, "_pulse"}, {31'h0, out_valid}, 32'd0);
    endtask

    initial begin
        int lat, busy_bad, n1, n2, extra, v;
        bit seen;

        // Reset
        rst      = 1'b0;
        in_valid = 1'b0;
        bin_in   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_ready", {31'h0, in_ready}, 32'd1);
        check_eq("rst_valid", {31'h0, out_valid}, 32'd0);
        check_eq("rst_bcd", {16'h0, bcd_out}, 32'h0);
        check_eq("rst_ovf", {31'h0, overflow}, 32'd0);

        // Single conversion and limits
        check_conv("c1234", 1234);
        check_conv("c0", 0);
        check_conv("c9999", 9999);
        check_conv("c10000", 10000);
        check_conv("c16383", 16383);

        // Back-to-back: in_valid held across the first result
        @(negedge clk);
        bin_in   = 14'd42;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        bin_in = 14'd507;
        n1 = 0;
        n2 = 0;
        for (int i = 1; i <= 40 && n1 == 0; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) n1 = i;
        end
        check_eq("b2b_first", {16'h0, bcd_out}, {16'h0, ref_bcd(42)});
        check_eq("b2b_ready", {31'h0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = n1 + 1; i <= n1 + 40 && n2 == 0; i++) begin
            if (i > n1 + 1) begin
                @(posedge clk);
                #1;
            end
            if (out_valid) n2 = i;
        end
        check_eq("b2b_second", {16'h0, bcd_out}, {16'h0, ref_bcd(507)});
        check_eq("b2b_gap", 32'(n2 - n1), 32'd15);

        // Busy ignore
        run_conv(1234, 5, lat, busy_bad);
        check_eq("busy_lat", 32'(lat), 32'd14);
        check_eq("busy_bcd", {16'h0, bcd_out}, {16'h0, ref_bcd(1234)});
        extra = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) extra++;
        end
        check_eq("busy_extra", 32'(extra), 32'd0);

        // Reset mid-conversion at shift 7
        @(negedge clk);
        bin_in   = 14'd1234;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("mid_bcd", {16'h0, bcd_out}, 32'h0);
        check_eq("mid_ovf", {31'h0, overflow}, 32'd0);
        check_eq("mid_ready", {31'h0, in_ready}, 32'd1);
        extra = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) extra++;
        end
        check_eq("mid_novalid", 32'(extra), 32'd0);
        check_conv("c56", 56);

        // Randomized sweep across the full input range
        for (int k = 0; k < 30; k++) begin
            v = (k % 2 == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 9999));
            check_conv($sformatf("rnd%0d_%0d", k, v), v);
        end

        seen = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
